// File: rtl/interrupt_pkg.sv
// Shared constants and types for the interrupt controller and its priority encoder.
// Source indices, register addresses, vector base and the acknowledge FSM states.
package interrupt_pkg;

    localparam int NUM_IRQ = 5;

    localparam int IRQ_VBLANK = 0;
    localparam int IRQ_STAT   = 1;
    localparam int IRQ_TIMER  = 2;
    localparam int IRQ_SERIAL = 3;
    localparam int IRQ_JOYPAD = 4;

    localparam logic [15:0] IF_ADDR     = 16'hFF0F;
    localparam logic [15:0] IE_ADDR     = 16'hFFFF;
    localparam logic [15:0] VECTOR_BASE = 16'h0040;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } ack_state_e;

    // Restart address of source idx: sources sit 8 bytes apart from VECTOR_BASE.
    function automatic logic [15:0] irq_vector(input logic [2:0] idx);
        return VECTOR_BASE + {10'd0, idx, 3'b000};
    endfunction

endpackage

// File: rtl/priority_encoder_5.sv
// Lowest-set-bit priority encoder over five request lines (bit 0 wins).
// Produces the one-hot grant, its binary index and a valid flag.
module priority_encoder_5 (
    input  logic [4:0] req,
    output logic [4:0] grant,
    output logic [2:0] index,
    output logic       valid
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        grant = '0;
        index = '0;
        valid = 1'b0;
        // Scan high to low so the lowest set bit is the last one written.
        for (int i = 4; i >= 0; i--) begin
            if (req[i]) begin
                grant = 5'b00001 << i;
                index = 3'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// IF/IE register pair on the CPU bus with edge-latched peripheral requests and
// a three-state acknowledge handshake that captures the winning restart vector.
module interrupt_controller
    import interrupt_pkg::*;
(
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Enable,
    input  logic [15:0]        i_Address,
    input  logic [7:0]         i_Bus,
    input  logic               i_Bus_Out,
    input  logic               i_Bus_In,
    output logic [7:0]         o_Bus,
    output logic               o_Selected,
    input  logic [NUM_IRQ-1:0] i_Sources,
    output logic [NUM_IRQ-1:0] o_Interrupts,
    input  logic               i_Handle_Interrupt,
    output logic [15:0]        o_Vector,
    output logic               o_Ack_Valid
);

    logic [NUM_IRQ-1:0] if_q, if_d, prev_q, rise, ack_clear, grant;
    logic [7:0]         ie_q;
    logic [2:0]         win_idx;
    logic               win_valid;
    logic [15:0]        win_vector, vector_q;
    logic               ack_valid_q;
    logic               sel_if, sel_ie;
    ack_state_e         state_q, state_d;

    assign sel_if     = (i_Address == IF_ADDR);
    assign sel_ie     = (i_Address == IE_ADDR);
    assign o_Selected = sel_if | sel_ie;

    assign rise         = i_Sources & ~prev_q;
    assign o_Interrupts = if_q & ie_q[NUM_IRQ-1:0];

    priority_encoder_5 u_encoder (
        .req   (o_Interrupts),
        .grant (grant),
        .index (win_idx),
        .valid (win_valid)
    );

    assign win_vector = win_valid ? irq_vector(win_idx) : 16'h0000;

    // A same-cycle peripheral rise must survive both a CPU write and an ack clear.
    assign if_d = (((i_Bus_Out && sel_if) ? i_Bus[NUM_IRQ-1:0] : if_q) & ~ack_clear) | rise;

    always_comb begin
        state_d   = state_q;
        ack_clear = '0;
        case (state_q)
            IDLE:    if (i_Handle_Interrupt) state_d = CAPTURE;
            CAPTURE: begin
                ack_clear = grant;
                state_d   = i_Handle_Interrupt ? HOLD : IDLE;
            end
            HOLD:    if (!i_Handle_Interrupt) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The vector is live during CAPTURE and replayed from the capture register in HOLD.
    always_comb begin
        o_Vector    = 16'h0000;
        o_Ack_Valid = 1'b0;
        if (state_q == CAPTURE) begin
            o_Vector    = win_vector;
            o_Ack_Valid = win_valid;
        end else if (state_q == HOLD) begin
            o_Vector    = vector_q;
            o_Ack_Valid = ack_valid_q;
        end
    end

    always_comb begin
        o_Bus = 8'h00;
        if (i_Bus_In && sel_if)
            o_Bus = {{(8 - NUM_IRQ){1'b1}}, if_q};
        else if (i_Bus_In && sel_ie)
            o_Bus = ie_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            if_q        <= '0;
            ie_q        <= '0;
            prev_q      <= '0;
            state_q     <= IDLE;
            vector_q    <= '0;
            ack_valid_q <= 1'b0;
        end else if (i_Enable) begin
            if_q    <= if_d;
            prev_q  <= i_Sources;
            state_q <= state_d;
            if (i_Bus_Out && sel_ie)
                ie_q <= i_Bus;
            if (state_q == CAPTURE) begin
                vector_q    <= win_vector;
                ack_valid_q <= win_valid;
            end else if (state_q == HOLD && !i_Handle_Interrupt) begin
                vector_q    <= '0;
                ack_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        rst, en, wr, rd, handle;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [4:0]  src;
    logic [7:0]  bus_rd;
    logic        sel;
    logic [4:0]  irq;
    logic [15:0] vec;
    logic        ack;

    always #5 clk = ~clk;

    interrupt_controller dut (
        .i_Clk              (clk),
        .i_Rst              (rst),
        .i_Enable           (en),
        .i_Address          (addr),
        .i_Bus              (wdata),
        .i_Bus_Out          (wr),
        .i_Bus_In           (rd),
        .o_Bus              (bus_rd),
        .o_Selected         (sel),
        .i_Sources          (src),
        .o_Interrupts       (irq),
        .i_Handle_Interrupt (handle),
        .o_Vector           (vec),
        .o_Ack_Valid        (ack)
    );

    typedef struct {
        string       name;
        bit          is_read;
        logic [7:0]  bus;
        logic [4:0]  irq;
        logic [15:0] vec;
        logic        ack;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic probe_req = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (probe_req) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                if (e.is_read) begin
                    check({e.name, "_bus"}, 32'(bus_rd), 32'(e.bus));
                    check({e.name, "_sel"}, 32'(sel), 32'd1);
                end else begin
                    check({e.name, "_irq"}, 32'(irq), 32'(e.irq));
                    check({e.name, "_vec"}, 32'(vec), 32'(e.vec));
                    check({e.name, "_ack"}, 32'(ack), 32'(e.ack));
                    check({e.name, "_idle_bus"}, 32'(bus_rd), 32'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_and_probe(input exp_t e);
        exp_q.push_back(e);
        probe_req = 1'b1;
        @(negedge clk);
        #1;
        probe_req = 1'b0;
    endtask

    task automatic probe_status(input string name, input logic [4:0] i,
                                input logic [15:0] v, input logic a);
        exp_t e;
        e.name = name; e.is_read = 1'b0; e.bus = 8'h00;
        e.irq = i; e.vec = v; e.ack = a;
        push_and_probe(e);
    endtask

    task automatic read_probe(input string name, input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        e.name = name; e.is_read = 1'b1; e.bus = d;
        e.irq = '0; e.vec = '0; e.ack = 1'b0;
        addr = a;
        rd   = 1'b1;
        push_and_probe(e);
        rd   = 1'b0;
        addr = 16'h0000;
    endtask

    task automatic write_reg(input logic [15:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        tick();
        wr    = 1'b0;
        addr  = 16'h0000;
        wdata = 8'h00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; wr = 1'b0; rd = 1'b0; handle = 1'b0;
        addr = 16'h0000; wdata = 8'h00; src = 5'b00000;

        // Reset state
        tick(); tick();
        probe_status("reset", 5'b00000, 16'h0000, 1'b0);
        rst = 1'b0;
        tick();
        read_probe("reset_if", 16'hFF0F, 8'hE0);
        read_probe("reset_ie", 16'hFFFF, 8'h00);

        // Edge latch on the timer line, held high across a software clear
        write_reg(16'hFFFF, 8'h1F);
        src[2] = 1'b1;
        tick();
        probe_status("edge_latch", 5'b00100, 16'h0000, 1'b0);
        read_probe("if_after_rise", 16'hFF0F, 8'hE4);
        tick();
        write_reg(16'hFF0F, 8'h00);
        read_probe("no_reset_while_high", 16'hFF0F, 8'hE0);
        probe_status("cleared", 5'b00000, 16'h0000, 1'b0);
        src = 5'b00000;
        tick();

        // Priority acknowledge: IF=10110 -> source 1 wins
        write_reg(16'hFF0F, 8'h16);
        probe_status("if_10110", 5'b10110, 16'h0000, 1'b0);
        handle = 1'b1;
        tick();
        probe_status("capture", 5'b10110, 16'h0048, 1'b1);
        tick();
        probe_status("hold", 5'b10100, 16'h0048, 1'b1);
        handle = 1'b0;
        tick();
        probe_status("release", 5'b10100, 16'h0000, 1'b0);
        read_probe("if_after_ack", 16'hFF0F, 8'hF4);

        // Cancelled dispatch: pending but masked
        write_reg(16'hFF0F, 8'h01);
        write_reg(16'hFFFF, 8'h00);
        handle = 1'b1;
        tick();
        probe_status("cancel_capture", 5'b00000, 16'h0000, 1'b0);
        tick();
        probe_status("cancel_hold", 5'b00000, 16'h0000, 1'b0);
        handle = 1'b0;
        tick();
        read_probe("if_after_cancel", 16'hFF0F, 8'hE1);

        // Collision: CPU write of 0 with a same-cycle rise on source 0
        write_reg(16'hFFFF, 8'h1F);
        addr = 16'hFF0F; wdata = 8'h00; wr = 1'b1; src[0] = 1'b1;
        tick();
        wr = 1'b0; addr = 16'h0000;
        read_probe("wr_vs_rise", 16'hFF0F, 8'hE1);
        src = 5'b00000;
        tick();

        // Collision: ack clear of bit 1 with a same-cycle rise on source 1
        write_reg(16'hFF0F, 8'h02);
        handle = 1'b1;
        tick();
        src[1] = 1'b1;
        tick();
        probe_status("ack_vs_rise_hold", 5'b00010, 16'h0048, 1'b1);
        handle = 1'b0;
        tick();
        read_probe("ack_vs_rise", 16'hFF0F, 8'hE2);
        src = 5'b00000;
        tick();

        // Higher priority arriving on the handshake-start cycle wins; HOLD ignores new requests
        handle = 1'b1; src[0] = 1'b1;
        tick();
        probe_status("late_high_prio", 5'b00011, 16'h0040, 1'b1);
        tick();
        src[2] = 1'b1;
        tick();
        probe_status("hold_new_req", 5'b00110, 16'h0040, 1'b1);
        handle = 1'b0;
        tick();
        probe_status("hold_release", 5'b00110, 16'h0000, 1'b0);
        src = 5'b00000;
        tick();

        // Handle dropped during CAPTURE: clear still happens, straight back to IDLE
        handle = 1'b1;
        tick();
        handle = 1'b0;
        probe_status("drop_in_capture", 5'b00110, 16'h0048, 1'b1);
        tick();
        probe_status("drop_cleared", 5'b00100, 16'h0000, 1'b0);

        // Enable gating: rise and write while disabled leave state untouched
        en = 1'b0; src[0] = 1'b1;
        addr = 16'hFF0F; wdata = 8'h1F; wr = 1'b1;
        tick(); tick();
        wr = 1'b0; addr = 16'h0000;
        read_probe("disabled_no_change", 16'hFF0F, 8'hE4);
        probe_status("disabled_irq", 5'b00100, 16'h0000, 1'b0);
        src = 5'b00000; en = 1'b1;
        tick();

        // IE keeps all eight bits
        write_reg(16'hFFFF, 8'hA5);
        read_probe("ie_full_byte", 16'hFFFF, 8'hA5);
        write_reg(16'hFFFF, 8'h1F);

        // Reset asserted in HOLD clears everything before the next edge
        write_reg(16'hFF0F, 8'h1C);
        handle = 1'b1;
        tick(); tick();
        probe_status("hold_before_reset", 5'b11000, 16'h0050, 1'b1);
        tick();
        rst = 1'b1;
        probe_status("reset_in_hold", 5'b00000, 16'h0000, 1'b0);
        handle = 1'b0;
        rst = 1'b0;
        tick();
        read_probe("if_after_reset", 16'hFF0F, 8'hE0);
        read_probe("ie_after_reset", 16'hFFFF, 8'h00);

        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
